// File: rtl/alu_arbiter.sv
// Two-requester front end for a shared combinational ALU: IDLE -> EXEC -> RESP handshake FSM.
// Arbitration is fixed-priority (requester 0 wins) unless ALU_ARB_ROUND_ROBIN_EN is defined.
module alu_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,

  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [3:0]       req0_op,

  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [3:0]       req1_op,

  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_control,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,

  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             rsp_src
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_EXEC = 2'b01,
    S_RESP = 2'b10
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [3:0]       r_op;
  logic             r_src;
  logic [WIDTH-1:0] r_rsp_result;
  logic             r_rsp_zero;
  logic             r_rsp_src;
  logic             r_rsp_valid;

  logic             w_grant0;
  logic             w_grant1;
  logic             w_idle;
  logic             w_exec;
  logic             w_accept;

`ifdef ALU_ARB_ROUND_ROBIN_EN
  // r_rr_ptr is the index favoured on the next tie, i.e. the complement of the
  // last grant; clearing it to 0 makes the first tie after reset go to requester 0.
  logic r_rr_ptr;

  // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_grant0 = 1'b0;
    w_grant1 = 1'b0;
    if (req0_valid && req1_valid) begin
      w_grant0 = ~r_rr_ptr;
      w_grant1 = r_rr_ptr;
    end else begin
      w_grant0 = req0_valid;
      w_grant1 = req1_valid;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr <= 1'b0;
    end else if (w_accept) begin
      r_rr_ptr <= w_grant0;
    end
  end
`else
  always_comb begin
    w_grant0 = req0_valid;
    w_grant1 = req1_valid & ~req0_valid;
  end
`endif

  // Ready is gated by rst_n so nothing is offered while reset is held low.
  assign w_idle     = (r_state == S_IDLE) & rst_n;
  assign w_exec     = (r_state == S_EXEC);
  assign req0_ready = w_idle & w_grant0;
  assign req1_ready = w_idle & w_grant1;
  assign w_accept   = req0_ready | req1_ready;

  assign alu_a       = w_exec ? r_a  : '0;
  assign alu_b       = w_exec ? r_b  : '0;
  assign alu_control = w_exec ? r_op : 4'b0000;

  assign rsp_valid  = r_rsp_valid;
  assign rsp_result = r_rsp_result;
  assign rsp_zero   = r_rsp_zero;
  assign rsp_src    = r_rsp_src;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_a          <= '0;
      r_b          <= '0;
      r_op         <= 4'b0000;
      r_src        <= 1'b0;
      r_rsp_result <= '0;
      r_rsp_zero   <= 1'b0;
      r_rsp_src    <= 1'b0;
      r_rsp_valid  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_a     <= w_grant1 ? req1_a  : req0_a;
            r_b     <= w_grant1 ? req1_b  : req0_b;
            r_op    <= w_grant1 ? req1_op : req0_op;
            r_src   <= w_grant1;
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_rsp_result <= alu_result;
          r_rsp_zero   <= alu_zero;
          r_rsp_src    <= r_src;
          r_rsp_valid  <= 1'b1;
          r_state      <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small behavioural ALU on the shared ALU port.
// Inputs change on the falling edge; outputs are checked on the falling edge (or 1ns after a drive).
module tb_alu_arbiter;

  localparam int WIDTH = 32;

  logic             clk;
  logic             rst_n;
  logic             req0_valid, req1_valid;
  logic             req0_ready, req1_ready;
  logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]       req0_op, req1_op;
  logic [WIDTH-1:0] alu_a, alu_b, alu_result;
  logic [3:0]       alu_control;
  logic             alu_zero;
  logic             rsp_valid, rsp_ready, rsp_zero, rsp_src;
  logic [WIDTH-1:0] rsp_result;

  int n_checks;
  int n_errors;

  alu_arbiter #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_op    (req0_op),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_op    (req1_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_control(alu_control),
    .alu_result (alu_result),
    .alu_zero   (alu_zero),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_zero   (rsp_zero),
    .rsp_src    (rsp_src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared ALU: add, sub, and, or; any other code returns 0.
  always_comb begin
    case (alu_control)
      4'b0000: alu_result = alu_a + alu_b;
      4'b0001: alu_result = alu_a - alu_b;
      4'b0010: alu_result = alu_a & alu_b;
      4'b0011: alu_result = alu_a | alu_b;
      default: alu_result = '0;
    endcase
    alu_zero = (alu_result == '0);
  end

  task automatic test_reset();
    rst_n = 1'b0;
    req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd2; req0_op = 4'b0000;
    req1_valid = 1'b1; req1_a = 32'd3; req1_b = 32'd4; req1_op = 4'b0000;
    @(negedge clk);
    n_checks++;
    if ({req0_ready, req1_ready} !== 2'b00) begin
      n_errors++; $display("FAIL reset_ready: got %b expected 00", {req0_ready, req1_ready});
    end
    n_checks++;
    if ({alu_a, alu_b, alu_control} !== '0) begin
      n_errors++; $display("FAIL reset_alu: got a=%0h b=%0h c=%0h expected 0", alu_a, alu_b, alu_control);
    end
    n_checks++;
    if ({rsp_valid, rsp_result, rsp_zero, rsp_src} !== '0) begin
      n_errors++; $display("FAIL reset_rsp: got v=%b r=%0h z=%b s=%b expected 0", rsp_valid, rsp_result, rsp_zero, rsp_src);
    end
    rst_n = 1'b1;
    #1;
    n_checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      n_errors++; $display("FAIL first_grant: got %b expected 10", {req0_ready, req1_ready});
    end
    // Withdraw both before the next edge: nothing may be accepted.
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({rsp_valid, alu_a, alu_control} !== '0) begin
      n_errors++; $display("FAIL withdraw: got v=%b a=%0h c=%0h expected 0", rsp_valid, alu_a, alu_control);
    end
  endtask

  // Issue one operation from a sole requester and check every phase.
  task automatic run_single(input string name, input logic src, input logic [WIDTH-1:0] a,
                            input logic [WIDTH-1:0] b, input logic [3:0] op,
                            input logic [WIDTH-1:0] exp_res, input logic exp_zero);
    @(negedge clk);
    if (src) begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op;
    end else begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op;
    end
    #1;
    n_checks++;
    if ({req1_ready, req0_ready} !== (src ? 2'b10 : 2'b01)) begin
      n_errors++; $display("FAIL %s_ready: got r1r0=%b expected src=%b", name, {req1_ready, req0_ready}, src);
    end
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    n_checks++;
    if ({alu_a, alu_b, alu_control, rsp_valid} !== {a, b, op, 1'b0}) begin
      n_errors++; $display("FAIL %s_exec: got a=%0h b=%0h c=%0h v=%b expected a=%0h b=%0h c=%0h v=0",
                           name, alu_a, alu_b, alu_control, rsp_valid, a, b, op);
    end
    @(negedge clk);
    n_checks++;
    if ({rsp_valid, rsp_result, rsp_zero, rsp_src} !== {1'b1, exp_res, exp_zero, src}) begin
      n_errors++; $display("FAIL %s_rsp: got v=%b r=%0h z=%b s=%b expected v=1 r=%0h z=%b s=%b",
                           name, rsp_valid, rsp_result, rsp_zero, rsp_src, exp_res, exp_zero, src);
    end
    @(negedge clk);
    n_checks++;
    if ({rsp_valid, alu_control} !== 5'b0) begin
      n_errors++; $display("FAIL %s_done: got v=%b c=%0h expected 0", name, rsp_valid, alu_control);
    end
  endtask

  task automatic test_single_op();
    run_single("single", 1'b0, 32'd5, 32'd3, 4'b0000, 32'd8, 1'b0);
  endtask

  task automatic test_zero_flag();
    run_single("zero", 1'b1, 32'd7, 32'd7, 4'b0001, 32'd0, 1'b1);
  endtask

  task automatic test_undefined_op();
    run_single("undef", 1'b0, 32'd1, 32'd1, 4'b1111, 32'd0, 1'b1);
  endtask

  task automatic test_contention();
    logic g;
    logic [WIDTH-1:0] exp_res;
    int n_r1;
    n_r1 = 0;
    @(negedge clk);
    req0_valid = 1'b1; req0_a = 32'd10; req0_b = 32'd1; req0_op = 4'b0000;
    req1_valid = 1'b1; req1_a = 32'd20; req1_b = 32'd2; req1_op = 4'b0001;
    for (int i = 0; i < 4; i++) begin
`ifdef ALU_ARB_ROUND_ROBIN_EN
      g = (i % 2 == 1);
`else
      g = 1'b0;
`endif
      exp_res = g ? 32'd18 : 32'd11;
      #1;
      if (req1_ready) n_r1++;
      n_checks++;
      if ({req1_ready, req0_ready} !== (g ? 2'b10 : 2'b01)) begin
        n_errors++; $display("FAIL cont_grant%0d: got r1r0=%b expected grant=%0d", i, {req1_ready, req0_ready}, g);
      end
      @(negedge clk);
      if (req1_ready) n_r1++;
      n_checks++;
      if ({req1_ready, req0_ready} !== 2'b00) begin
        n_errors++; $display("FAIL cont_exec_ready%0d: got %b expected 00", i, {req1_ready, req0_ready});
      end
      @(negedge clk);
      if (req1_ready) n_r1++;
      n_checks++;
      if ({rsp_valid, rsp_src, rsp_result, req1_ready, req0_ready} !== {1'b1, g, exp_res, 2'b00}) begin
        n_errors++; $display("FAIL cont_rsp%0d: got v=%b s=%b r=%0h rdy=%b expected v=1 s=%b r=%0h rdy=00",
                             i, rsp_valid, rsp_src, rsp_result, {req1_ready, req0_ready}, g, exp_res);
      end
      @(negedge clk);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
`ifndef ALU_ARB_ROUND_ROBIN_EN
    n_checks++;
    if (n_r1 != 0) begin
      n_errors++; $display("FAIL cont_req1_never: got %0d req1 grants expected 0", n_r1);
    end
`endif
    @(negedge clk);
  endtask

  task automatic test_back_pressure();
    @(negedge clk);
    req0_valid = 1'b1; req0_a = 32'd100; req0_b = 32'd23; req0_op = 4'b0000;
    rsp_ready = 1'b0;
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_a = 32'd9; req1_b = 32'd4; req1_op = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if ({rsp_valid, rsp_result, rsp_zero, rsp_src, req0_ready, req1_ready} !== {1'b1, 32'd123, 1'b0, 1'b0, 2'b00}) begin
        n_errors++; $display("FAIL bp_hold%0d: got v=%b r=%0h z=%b s=%b rdy=%b expected v=1 r=7b z=0 s=0 rdy=00",
                             i, rsp_valid, rsp_result, rsp_zero, rsp_src, {req0_ready, req1_ready});
      end
    end
    rsp_ready = 1'b1;
    #1;
    n_checks++;
    if ({req0_ready, req1_ready} !== 2'b00) begin
      n_errors++; $display("FAIL bp_no_accept_on_rsp: got %b expected 00", {req0_ready, req1_ready});
    end
    @(negedge clk);
    n_checks++;
    if ({rsp_valid, req1_ready} !== 2'b01) begin
      n_errors++; $display("FAIL bp_next_grant: got v=%b r1=%b expected v=0 r1=1", rsp_valid, req1_ready);
    end
    @(negedge clk);
    req1_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({rsp_valid, rsp_result, rsp_src} !== {1'b1, 32'd5, 1'b1}) begin
      n_errors++; $display("FAIL bp_second_rsp: got v=%b r=%0h s=%b expected v=1 r=5 s=1", rsp_valid, rsp_result, rsp_src);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_op();
    @(negedge clk);
    req1_valid = 1'b1; req1_a = 32'd3; req1_b = 32'd4; req1_op = 4'b0000;
    @(negedge clk);
    req1_valid = 1'b0;
    n_checks++;
    if (alu_a !== 32'd3) begin
      n_errors++; $display("FAIL rst_mid_exec: got a=%0h expected 3", alu_a);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({alu_a, alu_b, alu_control, rsp_valid, rsp_result, req0_ready, req1_ready} !== '0) begin
      n_errors++; $display("FAIL rst_mid_async: got a=%0h b=%0h c=%0h v=%b r=%0h expected 0",
                           alu_a, alu_b, alu_control, rsp_valid, rsp_result);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if ({rsp_valid, alu_control} !== 5'b0) begin
        n_errors++; $display("FAIL rst_mid_discard%0d: got v=%b c=%0h expected 0", i, rsp_valid, alu_control);
      end
    end
  endtask

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    rsp_ready  = 1'b1;
    test_reset();
    test_single_op();
    test_zero_flag();
    test_contention();
    test_back_pressure();
    test_undefined_op();
    test_reset_mid_op();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
